// File: rtl/reg_file_sb.sv
// Register file with same-cycle write bypass and a per-register busy scoreboard
// so decode can detect read-after-write hazards against in-flight producers.
module reg_file_sb #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int ZERO_REG   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] reg1_addr,
   input  logic [ADDR_WIDTH-1:0] reg2_addr,
   output logic [DATA_WIDTH-1:0] reg1_data,
   output logic [DATA_WIDTH-1:0] reg2_data,
   output logic                  reg1_busy,
   output logic                  reg2_busy,
   input  logic [ADDR_WIDTH-1:0] regw_addr,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic                  write_ena,
   input  logic [ADDR_WIDTH-1:0] issue_addr,
   input  logic                  issue_ena,
   output logic [ADDR_WIDTH:0]   busy_count
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] r_regs [DEPTH];
   logic [DEPTH-1:0]      r_busy;
   logic [ADDR_WIDTH:0]   r_busy_count;

   logic w_zero_w;
   logic w_zero_i;
   logic w_zero_1;
   logic w_zero_2;
   logic w_wr_eff;
   logic w_iss_eff;
   logic w_set;
   logic w_clr;

   assign w_zero_w = (ZERO_REG != 0) && (regw_addr  == '0);
   assign w_zero_i = (ZERO_REG != 0) && (issue_addr == '0);
   assign w_zero_1 = (ZERO_REG != 0) && (reg1_addr  == '0);
   assign w_zero_2 = (ZERO_REG != 0) && (reg2_addr  == '0);

   assign w_wr_eff  = write_ena && !w_zero_w;
   assign w_iss_eff = issue_ena && !w_zero_i;

   // A write that collides with an issue to the same register leaves it busy,
   // so it must not also decrement the count.
   assign w_set = w_iss_eff && !r_busy[issue_addr];
   assign w_clr = w_wr_eff && r_busy[regw_addr] &&
                  !(w_iss_eff && (issue_addr == regw_addr));

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_regs[i] <= '0;
         end
         r_busy       <= '0;
         r_busy_count <= '0;
      end else begin
         if (w_wr_eff) begin
            r_regs[regw_addr] <= write_data;
         end
         // Issue is applied after the write clear so the new producer wins.
         for (int i = 0; i < DEPTH; i++) begin
            if (w_iss_eff && (issue_addr == ADDR_WIDTH'(i))) begin
               r_busy[i] <= 1'b1;
            end else if (w_wr_eff && (regw_addr == ADDR_WIDTH'(i))) begin
               r_busy[i] <= 1'b0;
            end
         end
         r_busy_count <= r_busy_count + {{ADDR_WIDTH{1'b0}}, w_set}
                                      - {{ADDR_WIDTH{1'b0}}, w_clr};
      end
   end

   always_comb begin
      reg1_data = r_regs[reg1_addr];
      reg1_busy = r_busy[reg1_addr];
      if (w_zero_1) begin
         reg1_data = '0;
         reg1_busy = 1'b0;
      end else if (write_ena && (regw_addr == reg1_addr)) begin
         reg1_data = write_data;
         reg1_busy = 1'b0;
      end
   end

   always_comb begin
      reg2_data = r_regs[reg2_addr];
      reg2_busy = r_busy[reg2_addr];
      if (w_zero_2) begin
         reg2_data = '0;
         reg2_busy = 1'b0;
      end else if (write_ena && (regw_addr == reg2_addr)) begin
         reg2_data = write_data;
         reg2_busy = 1'b0;
      end
   end

   assign busy_count = r_busy_count;

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed scenarios plus random traffic against a
// reference model, on one instance with a hardwired zero register and one without.
module tb_reg_file_sb;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int D  = 1 << AW;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] reg1_addr, reg2_addr, regw_addr, issue_addr;
   logic [DW-1:0] write_data;
   logic          write_ena, issue_ena;

   logic [DW-1:0] a_r1d, a_r2d, b_r1d, b_r2d;
   logic          a_r1b, a_r2b, b_r1b, b_r2b;
   logic [AW:0]   a_cnt, b_cnt;

   int n_cmp = 0;
   int n_err = 0;
   bit m_valid = 1'b0;

   // index 0 models the ZERO_REG=1 instance, index 1 the ZERO_REG=0 instance
   logic [DW-1:0] m_regs [2][D];
   bit            m_busy [2][D];

   always #5 clk = ~clk;

   reg_file_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1)) u_dut_a (
      .clk(clk), .rst(rst),
      .reg1_addr(reg1_addr), .reg2_addr(reg2_addr),
      .reg1_data(a_r1d), .reg2_data(a_r2d),
      .reg1_busy(a_r1b), .reg2_busy(a_r2b),
      .regw_addr(regw_addr), .write_data(write_data), .write_ena(write_ena),
      .issue_addr(issue_addr), .issue_ena(issue_ena),
      .busy_count(a_cnt)
   );

   reg_file_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(0)) u_dut_b (
      .clk(clk), .rst(rst),
      .reg1_addr(reg1_addr), .reg2_addr(reg2_addr),
      .reg1_data(b_r1d), .reg2_data(b_r2d),
      .reg1_busy(b_r1b), .reg2_busy(b_r2b),
      .regw_addr(regw_addr), .write_data(write_data), .write_ena(write_ena),
      .issue_addr(issue_addr), .issue_ena(issue_ena),
      .busy_count(b_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] exp_data(input int k, input logic [AW-1:0] a);
      if (k == 0 && a == 0) return '0;
      if (write_ena && regw_addr == a) return write_data;
      return m_regs[k][a];
   endfunction

   function automatic logic exp_busy(input int k, input logic [AW-1:0] a);
      if (k == 0 && a == 0) return 1'b0;
      if (write_ena && regw_addr == a) return 1'b0;
      return m_busy[k][a];
   endfunction

   function automatic int exp_cnt(input int k);
      int s = 0;
      for (int i = 0; i < D; i++) s += int'(m_busy[k][i]);
      return s;
   endfunction

   task automatic check_model();
      chk("a_r1d", a_r1d, exp_data(0, reg1_addr));
      chk("a_r2d", a_r2d, exp_data(0, reg2_addr));
      chk("a_r1b", a_r1b, exp_busy(0, reg1_addr));
      chk("a_r2b", a_r2b, exp_busy(0, reg2_addr));
      chk("a_cnt", a_cnt, exp_cnt(0));
      chk("b_r1d", b_r1d, exp_data(1, reg1_addr));
      chk("b_r2d", b_r2d, exp_data(1, reg2_addr));
      chk("b_r1b", b_r1b, exp_busy(1, reg1_addr));
      chk("b_r2b", b_r2b, exp_busy(1, reg2_addr));
      chk("b_cnt", b_cnt, exp_cnt(1));
   endtask

   task automatic model_edge();
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            for (int i = 0; i < D; i++) begin
               m_regs[k][i] = '0;
               m_busy[k][i] = 1'b0;
            end
         end else begin
            if (write_ena && !(k == 0 && regw_addr == 0)) begin
               m_regs[k][regw_addr] = write_data;
               m_busy[k][regw_addr] = 1'b0;
            end
            if (issue_ena && !(k == 0 && issue_addr == 0))
               m_busy[k][issue_addr] = 1'b1;
         end
      end
   endtask

   task automatic tick();
      #1;
      if (m_valid) check_model();
      @(posedge clk);
      model_edge();
      if (rst) m_valid = 1'b1;
      @(negedge clk);
   endtask

   task automatic set(input logic r, input logic we, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd, input logic ie, input logic [AW-1:0] ia,
                      input logic [AW-1:0] a1, input logic [AW-1:0] a2);
      rst = r; write_ena = we; regw_addr = wa; write_data = wd;
      issue_ena = ie; issue_addr = ia; reg1_addr = a1; reg2_addr = a2;
   endtask

   initial begin
      set(1, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);

      set(1, 0, 0, 0, 0, 0, 1, 2); tick(); tick();

      set(0, 0, 0, 0, 0, 0, 1, 2); #1;
      chk("rst_r1d", a_r1d, 0); chk("rst_r2d", a_r2d, 0);
      chk("rst_r1b", a_r1b, 0); chk("rst_r2b", a_r2b, 0);
      chk("rst_cnt", a_cnt, 0);
      tick();

      set(0, 1, 1, 32'h0000FFFF, 0, 0, 1, 2); #1;
      chk("bypass", a_r1d, 32'h0000FFFF);
      tick();
      set(0, 0, 0, 0, 0, 0, 1, 2); #1;
      chk("wr_hold", a_r1d, 32'h0000FFFF);
      tick();

      set(0, 0, 0, 0, 1, 3, 3, 0); tick();
      set(0, 0, 0, 0, 1, 5, 3, 0); #1;
      chk("cnt_1", a_cnt, 1); chk("busy3", a_r1b, 1);
      tick();
      set(0, 0, 0, 0, 0, 0, 3, 5); #1;
      chk("cnt_2", a_cnt, 2); chk("busy5", a_r2b, 1);
      tick();
      set(0, 1, 3, 32'hFFFF0000, 0, 0, 3, 5); #1;
      chk("byp_busy", a_r1b, 0);
      tick();
      set(0, 0, 0, 0, 0, 0, 3, 5); #1;
      chk("clr_cnt", a_cnt, 1); chk("clr_busy", a_r1b, 0);
      chk("clr_data", a_r1d, 32'hFFFF0000);
      tick();

      set(0, 1, 4, 32'h12345678, 1, 4, 4, 0); tick();
      set(0, 0, 0, 0, 0, 0, 4, 0); #1;
      chk("coll_busy", a_r1b, 1); chk("coll_data", a_r1d, 32'h12345678);
      chk("coll_cnt", a_cnt, 2);
      tick();
      set(0, 0, 0, 0, 1, 4, 4, 0); tick();
      set(0, 0, 0, 0, 0, 0, 4, 0); #1;
      chk("waw_cnt", a_cnt, 2);
      tick();

      set(0, 1, 0, 32'hDEADBEEF, 1, 0, 0, 0); #1;
      chk("z_nobyp", a_r1d, 0); chk("nz_byp", b_r1d, 32'hDEADBEEF);
      tick();
      set(0, 0, 0, 0, 0, 0, 0, 0); #1;
      chk("z_data", a_r1d, 0); chk("z_busy", a_r1b, 0); chk("z_cnt", a_cnt, 2);
      chk("nz_data", b_r1d, 32'hDEADBEEF); chk("nz_busy", b_r1b, 1);
      chk("nz_cnt", b_cnt, 3);
      tick();

      set(0, 0, 0, 0, 1, 6, 0, 0); tick();
      set(1, 1, 7, 32'hAAAA5555, 0, 0, 7, 5); #1;
      chk("pre_rst_cnt", a_cnt, 3);
      tick();
      set(0, 0, 0, 0, 0, 0, 7, 5); #1;
      chk("mid_rst_cnt", a_cnt, 0); chk("mid_rst_d7", a_r1d, 0);
      chk("mid_rst_b7", a_r1b, 0); chk("mid_rst_b5", a_r2b, 0);
      chk("mid_rst_bcnt", b_cnt, 0);
      tick();

      for (int n = 0; n < 600; n++) begin
         logic [AW-1:0] lim;
         lim = ($urandom_range(0, 3) == 0) ? AW'(D - 1) : AW'(7);
         set(($urandom_range(0, 79) == 0),
             1'($urandom), AW'($urandom_range(0, int'(lim))), DW'($urandom),
             1'($urandom), AW'($urandom_range(0, int'(lim))),
             AW'($urandom_range(0, int'(lim))), AW'($urandom_range(0, int'(lim))));
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
